// File: rtl/sonic_tx_arb_pkg.sv
// Shared types and constants for the PCIe TX/MSI arbiter slice.
package sonic_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int MSI_NUM_W = 5;
  localparam int MSI_TC_W  = 3;

endpackage

// File: rtl/sonic_tx_arbiter_if.sv
// Core-side TX descriptor/data and MSI request bundle between arbiter and PCIe hard IP.
interface sonic_tx_arbiter_if #(
  parameter int DATA_WIDTH = 128
);
  import sonic_tx_arb_pkg::*;

  logic                  tx_req;
  logic                  tx_dfr;
  logic                  tx_dv;
  logic                  tx_err;
  logic [DATA_WIDTH-1:0] tx_desc;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ack;
  logic                  tx_ws;

  logic                  app_msi_req;
  logic [MSI_NUM_W-1:0]  app_msi_num;
  logic [MSI_TC_W-1:0]   app_msi_tc;
  logic                  app_msi_ack;

  modport master (
    output tx_req, tx_dfr, tx_dv, tx_err, tx_desc, tx_data,
    output app_msi_req, app_msi_num, app_msi_tc,
    input  tx_ack, tx_ws, app_msi_ack
  );

  modport slave (
    input  tx_req, tx_dfr, tx_dv, tx_err, tx_desc, tx_data,
    input  app_msi_req, app_msi_num, app_msi_tc,
    output tx_ack, tx_ws, app_msi_ack
  );

endinterface

// File: rtl/sonic_rr_arbiter.sv
// Non-preemptive round-robin grant FSM (IDLE/GRANT/BUSY) with registered one-hot grant.
module sonic_rr_arbiter
  import sonic_tx_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] ready,
  input  logic [N-1:0] busy,
  output logic [N-1:0] sel,
  output logic         active
);

  localparam int IW = $clog2(N);

  arb_state_t    state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic          pick_ok;
  int unsigned   idx;

  // First ready client at or after last+1, wrapping modulo N.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_ok && ready[idx[IW-1:0]]) begin
        pick_ok = 1'b1;
        pick    = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      active <= 1'b0;
      last   <= IW'(N - 1);
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            sel    <= N'(1) << pick;
            owner  <= pick;
            active <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          // An abandoned grant does not advance the round-robin pointer.
          if (busy[owner]) begin
            state <= BUSY;
          end else if (!ready[owner]) begin
            sel    <= '0;
            active <= 1'b0;
            state  <= IDLE;
          end
        end
        BUSY: begin
          if (!busy[owner]) begin
            sel    <= '0;
            active <= 1'b0;
            last   <= owner;
            state  <= IDLE;
          end
        end
        default: begin
          sel    <= '0;
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sonic_tx_arbiter.sv
// Shares the PCIe TX and MSI ports among NUM_CLIENTS requesters.
// Define SONIC_TX_ARB_MSI_EN for MSI round-robin; otherwise client 0 owns MSI.
module sonic_tx_arbiter
  import sonic_tx_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 3,
  parameter int DATA_WIDTH  = 128
) (
  input  logic                              clk_in,
  input  logic                              rstn,
  input  logic [NUM_CLIENTS-1:0]            cl_tx_ready,
  input  logic [NUM_CLIENTS-1:0]            cl_tx_busy,
  input  logic [NUM_CLIENTS-1:0]            cl_tx_req,
  input  logic [NUM_CLIENTS-1:0]            cl_tx_dfr,
  input  logic [NUM_CLIENTS-1:0]            cl_tx_dv,
  input  logic [NUM_CLIENTS-1:0]            cl_tx_err,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_tx_desc,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_tx_data,
  output logic [NUM_CLIENTS-1:0]            tx_sel,
  output logic [NUM_CLIENTS-1:0]            cl_tx_ack,
  output logic [NUM_CLIENTS-1:0]            cl_tx_ws,
  output logic [NUM_CLIENTS-1:0]            tx_ready_others,
  input  logic [NUM_CLIENTS-1:0]            cl_msi_ready,
  input  logic [NUM_CLIENTS-1:0]            cl_msi_busy,
  input  logic [NUM_CLIENTS-1:0]            cl_app_msi_req,
  input  logic [NUM_CLIENTS*MSI_NUM_W-1:0]  cl_app_msi_num,
  input  logic [NUM_CLIENTS*MSI_TC_W-1:0]   cl_app_msi_tc,
  output logic [NUM_CLIENTS-1:0]            msi_sel,
  output logic [NUM_CLIENTS-1:0]            cl_app_msi_ack,
  sonic_tx_arbiter_if.master                core
);

  localparam int N  = NUM_CLIENTS;
  localparam int DW = DATA_WIDTH;

  logic          tx_active;
  logic          req_m, dfr_m, dv_m, err_m;
  logic [DW-1:0] desc_m, data_m;

  sonic_rr_arbiter #(.N(N)) u_tx_arb (
    .clk    (clk_in),
    .rst_n  (rstn),
    .ready  (cl_tx_ready),
    .busy   (cl_tx_busy),
    .sel    (tx_sel),
    .active (tx_active)
  );

  always_comb begin
    req_m  = 1'b0;
    dfr_m  = 1'b0;
    dv_m   = 1'b0;
    err_m  = 1'b0;
    desc_m = '0;
    data_m = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (tx_active && tx_sel[i]) begin
        req_m  = req_m  | cl_tx_req[i];
        dfr_m  = dfr_m  | cl_tx_dfr[i];
        dv_m   = dv_m   | cl_tx_dv[i];
        err_m  = err_m  | cl_tx_err[i];
        desc_m = desc_m | cl_tx_desc[i*DW +: DW];
        data_m = data_m | cl_tx_data[i*DW +: DW];
      end
    end
  end

  assign core.tx_req  = req_m;
  assign core.tx_dfr  = dfr_m;
  assign core.tx_dv   = dv_m;
  assign core.tx_err  = err_m;
  assign core.tx_desc = desc_m;
  assign core.tx_data = data_m;

  // Non-grantees see wait-state asserted so they never advance on a stale ws.
  assign cl_tx_ack = tx_sel & {N{core.tx_ack}};
  assign cl_tx_ws  = ~tx_sel | {N{core.tx_ws}};

  always_comb begin
    tx_ready_others = '0;
    for (int unsigned i = 0; i < N; i++) begin
      tx_ready_others[i] = |(cl_tx_ready & ~(N'(1) << i));
    end
  end

`ifdef SONIC_TX_ARB_MSI_EN
  logic                 msi_active;
  logic                 msi_req_m;
  logic [MSI_NUM_W-1:0] msi_num_m;
  logic [MSI_TC_W-1:0]  msi_tc_m;

  sonic_rr_arbiter #(.N(N)) u_msi_arb (
    .clk    (clk_in),
    .rst_n  (rstn),
    .ready  (cl_msi_ready),
    .busy   (cl_msi_busy),
    .sel    (msi_sel),
    .active (msi_active)
  );

  always_comb begin
    msi_req_m = 1'b0;
    msi_num_m = '0;
    msi_tc_m  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (msi_active && msi_sel[i]) begin
        msi_req_m = msi_req_m | cl_app_msi_req[i];
        msi_num_m = msi_num_m | cl_app_msi_num[i*MSI_NUM_W +: MSI_NUM_W];
        msi_tc_m  = msi_tc_m  | cl_app_msi_tc[i*MSI_TC_W +: MSI_TC_W];
      end
    end
  end

  assign core.app_msi_req = msi_req_m;
  assign core.app_msi_num = msi_num_m;
  assign core.app_msi_tc  = msi_tc_m;
  assign cl_app_msi_ack   = msi_sel & {N{core.app_msi_ack}};
`else
  logic unused_msi;

  assign msi_sel          = N'(1);
  assign core.app_msi_req = cl_app_msi_req[0];
  assign core.app_msi_num = cl_app_msi_num[MSI_NUM_W-1:0];
  assign core.app_msi_tc  = cl_app_msi_tc[MSI_TC_W-1:0];
  assign cl_app_msi_ack   = {{(N-1){1'b0}}, core.app_msi_ack};
  assign unused_msi       = ^{cl_msi_ready, cl_msi_busy, cl_app_msi_req[N-1:1],
                              cl_app_msi_num[N*MSI_NUM_W-1:MSI_NUM_W],
                              cl_app_msi_tc[N*MSI_TC_W-1:MSI_TC_W]};
`endif

endmodule

// File: tb/tb_sonic_tx_arbiter.sv
// Scoreboard bench for sonic_tx_arbiter: directed grant sequences, mux/return routing, async reset, MSI.
module tb_sonic_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 128;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   cl_tx_ready, cl_tx_busy, cl_tx_req, cl_tx_dfr, cl_tx_dv, cl_tx_err;
  logic [N*DW-1:0] cl_tx_desc, cl_tx_data;
  logic [N-1:0]   tx_sel, cl_tx_ack, cl_tx_ws, tx_ready_others;
  logic [N-1:0]   cl_msi_ready, cl_msi_busy, cl_app_msi_req;
  logic [N*5-1:0] cl_app_msi_num;
  logic [N*3-1:0] cl_app_msi_tc;
  logic [N-1:0]   msi_sel, cl_app_msi_ack;

  sonic_tx_arbiter_if #(.DATA_WIDTH(DW)) core_if ();

  sonic_tx_arbiter #(.NUM_CLIENTS(N), .DATA_WIDTH(DW)) dut (
    .clk_in          (clk),
    .rstn            (rstn),
    .cl_tx_ready     (cl_tx_ready),
    .cl_tx_busy      (cl_tx_busy),
    .cl_tx_req       (cl_tx_req),
    .cl_tx_dfr       (cl_tx_dfr),
    .cl_tx_dv        (cl_tx_dv),
    .cl_tx_err       (cl_tx_err),
    .cl_tx_desc      (cl_tx_desc),
    .cl_tx_data      (cl_tx_data),
    .tx_sel          (tx_sel),
    .cl_tx_ack       (cl_tx_ack),
    .cl_tx_ws        (cl_tx_ws),
    .tx_ready_others (tx_ready_others),
    .cl_msi_ready    (cl_msi_ready),
    .cl_msi_busy     (cl_msi_busy),
    .cl_app_msi_req  (cl_app_msi_req),
    .cl_app_msi_num  (cl_app_msi_num),
    .cl_app_msi_tc   (cl_app_msi_tc),
    .msi_sel         (msi_sel),
    .cl_app_msi_ack  (cl_app_msi_ack),
    .core            (core_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sel;
    logic [DW-1:0] val;
  } exp_t;

  exp_t tx_q[$];
  exp_t msi_q[$];
  exp_t tx_e, msi_e;
  int checks = 0;
  int errors = 0;
  logic [N-1:0] prev_tx  = '0;
  logic [N-1:0] prev_msi = '0;

  function automatic logic [DW-1:0] desc_of(input int i);
    return {4{32'hDE5C_0A00 + 32'(i)}};
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return {4{32'hDA7A_0B00 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input int i);
    exp_t e;
    e.sel = N'(1) << i;
    e.val = desc_of(i);
    tx_q.push_back(e);
  endtask

  // Waits (bounded) for the grant, runs a busy burst, optionally withdraws ready bits.
  task automatic serve(input int i, input int nbusy, input logic [N-1:0] clr, input bit msi);
    int t = 0;
    while (!(msi ? msi_sel[i] : tx_sel[i]) && t < 20) begin
      tick();
      t++;
    end
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL serve_wait: client %0d grant not seen within 20 cycles (msi=%0d)", i, msi);
    end
    if (msi) cl_msi_busy[i] = 1'b1; else cl_tx_busy[i] = 1'b1;
    repeat (nbusy) tick();
    if (msi) begin
      cl_msi_ready = cl_msi_ready & ~clr;
      cl_msi_busy[i] = 1'b0;
    end else begin
      cl_tx_ready = cl_tx_ready & ~clr;
      cl_tx_busy[i] = 1'b0;
    end
    tick();
  endtask

  // Monitor: every fresh grant (sel rising from zero) is matched against the scoreboard.
  always @(negedge clk) begin
    if (tx_sel != '0 && prev_tx == '0) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_grant: unexpected grant sel=%b, none expected", tx_sel);
      end else begin
        tx_e = tx_q.pop_front();
        if (tx_sel !== tx_e.sel || core_if.tx_desc !== tx_e.val) begin
          errors++;
          $display("FAIL tx_grant: got sel=%b desc=%0h, required sel=%b desc=%0h",
                   tx_sel, core_if.tx_desc, tx_e.sel, tx_e.val);
        end
      end
    end
    prev_tx = tx_sel;
  end

`ifdef SONIC_TX_ARB_MSI_EN
  always @(negedge clk) begin
    if (msi_sel != '0 && prev_msi == '0) begin
      checks++;
      if (msi_q.size() == 0) begin
        errors++;
        $display("FAIL msi_grant: unexpected grant sel=%b, none expected", msi_sel);
      end else begin
        msi_e = msi_q.pop_front();
        if (msi_sel !== msi_e.sel || core_if.app_msi_num !== msi_e.val[4:0]) begin
          errors++;
          $display("FAIL msi_grant: got sel=%b num=%0d, required sel=%b num=%0d",
                   msi_sel, core_if.app_msi_num, msi_e.sel, msi_e.val[4:0]);
        end
      end
    end
    prev_msi = msi_sel;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rstn           = 1'b0;
    cl_tx_ready    = '0;
    cl_tx_busy     = '0;
    cl_tx_req      = 3'b110;
    cl_tx_dfr      = 3'b010;
    cl_tx_dv       = 3'b011;
    cl_tx_err      = 3'b100;
    for (int i = 0; i < N; i++) begin
      cl_tx_desc[i*DW +: DW] = desc_of(i);
      cl_tx_data[i*DW +: DW] = data_of(i);
    end
    cl_msi_ready   = '0;
    cl_msi_busy    = '0;
    cl_app_msi_req = 3'b101;
    cl_app_msi_num = {5'd17, 5'd9, 5'd3};
    cl_app_msi_tc  = {3'd5, 3'd2, 3'd1};
    core_if.tx_ack      = 1'b0;
    core_if.tx_ws       = 1'b0;
    core_if.app_msi_ack = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_tx_sel", DW'(tx_sel), '0);
    chk("rst_tx_req", DW'(core_if.tx_req), '0);
    chk("rst_tx_desc", core_if.tx_desc, '0);
    chk("rst_cl_tx_ws", DW'(cl_tx_ws), DW'(3'b111));
    chk("rst_cl_tx_ack", DW'(cl_tx_ack), '0);
`ifdef SONIC_TX_ARB_MSI_EN
    chk("rst_msi_sel", DW'(msi_sel), '0);
`else
    chk("rst_msi_sel", DW'(msi_sel), DW'(3'b001));
`endif
    #3 rstn = 1'b1;
    tick();

    // Client 2 granted then withdraws without busy
    cl_tx_ready = 3'b100;
    push_tx(2);
    tick();
    chk("drop_grant", DW'(tx_sel), DW'(3'b100));
    tick();
    cl_tx_ready = 3'b000;
    tick();
    chk("drop_idle", DW'(tx_sel), '0);

    // All ready: 0,1,2,0 with an idle cycle between owners
    cl_tx_ready = 3'b111;
    #1 chk("others_111", DW'(tx_ready_others), DW'(3'b111));
    push_tx(0); push_tx(1); push_tx(2); push_tx(0);
    serve(0, 2, 3'b000, 1'b0);
    serve(1, 2, 3'b000, 1'b0);
    serve(2, 2, 3'b000, 1'b0);
    serve(0, 2, 3'b111, 1'b0);

    // Client 1 alone, busy for 5 cycles
    cl_tx_ready = 3'b010;
    #1 chk("others_010", DW'(tx_ready_others), DW'(3'b101));
    push_tx(1);
    tick();
    chk("c1_grant_latency", DW'(tx_sel), DW'(3'b010));
    cl_tx_busy[1] = 1'b1;
    repeat (5) begin
      tick();
      chk("c1_busy_desc", core_if.tx_desc, desc_of(1));
    end
    chk("c1_data", core_if.tx_data, data_of(1));
    chk("c1_ctrl", DW'({core_if.tx_req, core_if.tx_dfr, core_if.tx_dv, core_if.tx_err}), DW'(4'b1110));
    chk("c1_held", DW'(tx_sel), DW'(3'b010));
    cl_tx_busy[1] = 1'b0;
    cl_tx_ready   = 3'b000;
    tick();
    chk("c1_release", DW'(tx_sel), '0);

    // Abandoned grant leaves the pointer at client 1, so 0 and 2 ready picks 2
    cl_tx_ready = 3'b100;
    push_tx(2);
    tick();
    chk("c2_grant", DW'(tx_sel), DW'(3'b100));
    cl_tx_ready = 3'b000;
    tick();
    chk("c2_abandon", DW'(tx_sel), '0);
    cl_tx_ready = 3'b101;
    #1 chk("others_101", DW'(tx_ready_others), DW'(3'b111));
    push_tx(2);
    serve(2, 1, 3'b101, 1'b0);

    // Client 0 busy: return routing and a waiting request from client 1
    cl_tx_ready = 3'b001;
    push_tx(0);
    tick();
    chk("c0_grant", DW'(tx_sel), DW'(3'b001));
    cl_tx_busy[0] = 1'b1;
    tick();
    core_if.tx_ack = 1'b1;
    core_if.tx_ws  = 1'b1;
    cl_tx_ready[1] = 1'b1;
    push_tx(1);
    #1;
    chk("c0_ack", DW'(cl_tx_ack), DW'(3'b001));
    chk("c0_ws_hi", DW'(cl_tx_ws), DW'(3'b111));
    core_if.tx_ws = 1'b0;
    #1 chk("c0_ws_lo", DW'(cl_tx_ws), DW'(3'b110));
    repeat (3) tick();
    chk("c0_no_preempt", DW'(tx_sel), DW'(3'b001));
    cl_tx_busy[0]  = 1'b0;
    cl_tx_ready[0] = 1'b0;
    core_if.tx_ack = 1'b0;
    tick();
    chk("c0_release", DW'(tx_sel), '0);
    tick();
    chk("c1_after_wait", DW'(tx_sel), DW'(3'b010));

    // Asynchronous reset while client 1 is busy
    cl_tx_busy[1] = 1'b1;
    tick();
    chk("pre_rst_req_dv", DW'({core_if.tx_req, core_if.tx_dv}), DW'(2'b11));
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_sel", DW'(tx_sel), '0);
    chk("async_rst_req_dv", DW'({core_if.tx_req, core_if.tx_dv}), '0);
    cl_tx_busy  = '0;
    cl_tx_ready = '0;
    tick();
    rstn = 1'b1;
    tick();

    // MSI
`ifdef SONIC_TX_ARB_MSI_EN
    msi_e.sel = 3'b001; msi_e.val = DW'(5'd3);  msi_q.push_back(msi_e);
    msi_e.sel = 3'b100; msi_e.val = DW'(5'd17); msi_q.push_back(msi_e);
    cl_msi_ready = 3'b101;
    serve(0, 2, 3'b001, 1'b1);
    serve(2, 2, 3'b100, 1'b1);
    chk("msi_idle", DW'(msi_sel), '0);
`else
    core_if.app_msi_ack = 1'b1;
    cl_msi_ready = 3'b110;
    tick();
    chk("msi_sel_const", DW'(msi_sel), DW'(3'b001));
    chk("msi_passthru", DW'({core_if.app_msi_req, core_if.app_msi_num, core_if.app_msi_tc}),
        DW'({1'b1, 5'd3, 3'd1}));
    chk("msi_ack", DW'(cl_app_msi_ack), DW'(3'b001));
    cl_app_msi_num = {5'd17, 5'd9, 5'd12};
    core_if.app_msi_ack = 1'b0;
    #1 chk("msi_num_follow", DW'({core_if.app_msi_num, cl_app_msi_ack}), DW'({5'd12, 3'b000}));
`endif

    tick();
    chk("tx_queue_drained", DW'(tx_q.size()), '0);
    chk("msi_queue_drained", DW'(msi_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
